fp_normalize_pipe: RTL and testbench
====================================

// Module: fp_normalize_pipe
// PURPOSE
// - Two-stage elastic pipeline that normalises an unnormalised floating-point value.
// - Input is {sign, exponent, mantissa}; output has the mantissa's MSB set and the exponent reduced by the shift.
// - Consumes the leading-one position from detect_pos_first_one (D_WIDTH=MANT_W).
// - Sits after the adder/multiplier datapath and before packing/rounding.
// - Valid/ready on both sides; throughput 1 item per cycle.
// PARAMETERS
// - MANT_W  16  mantissa width (>=2); also D_WIDTH of the LZ detector
// - EXP_W    8  unsigned biased exponent width
// PORTS
// - clk_i      in   1                 clock, rising edge
// - rst_n_i    in   1                 asynchronous active-low reset
// - valid_i    in   1                 input item valid
// - ready_o    out  1                 block can accept an input this cycle
// - sign_i     in   1                 sign, passed through unchanged
// - exp_i      in   EXP_W             biased exponent
// - mant_i     in   MANT_W            unnormalised mantissa
// - valid_o    out  1                 output item valid
// - ready_i    in   1                 downstream accepts the output
// - sign_o     out  1                 sign
// - exp_o      out  EXP_W             adjusted exponent
// - mant_o     out  MANT_W            normalised mantissa
// - zero_o     out  1                 input mantissa was zero
// - uflow_o    out  1                 shift was limited by the exponent (result is denormal)
// BEHAVIOUR
// - Clock and reset:
//   - Single clock domain clk_i.
//   - Reset is asynchronous, active-low (rst_n_i), with synchronous deassertion done externally.
//   - While rst_n_i=0, all state clears immediately: s1_valid=0, s2_valid=0, all S1/S2 data registers 0.
//   - Reset values: valid_o=0, sign_o=0, exp_o=0, mant_o=0, zero_o=0, uflow_o=0.
//   - ready_o=1 as soon as reset is released.
// - Handshake rules:
//   - A transfer occurs when valid && ready are both high on a clock edge.
//   - valid_o and output data stay stable while valid_o=1 && ready_i=0.
//   - ready_o = !s1_valid | adv1, where adv1 = s1_valid & (!s2_valid | ready_i).
//   - The combinational path ready_i->ready_o is allowed.
//   - No combinational path from valid_i/data to valid_o/data.
// - Stage S1 (register and detect):
//   - On accept: capture sign, exp and mant; set s1_valid.
//   - s1_valid clears when adv1 fires and nothing new is accepted.
//   - The detector runs combinationally on s1_mant and gives lz = leading-zero count (0..MANT_W-1).
//   - Zero is detected locally: z = (s1_mant == 0).
//   - The detector output is don't-care when z=1 and is never used in that case.
// - Stage S2 (shift and adjust), loaded on adv1:
//   - z=1: mant=0, exp=0, zero=1, uflow=0.
//   - z=0 and lz<=exp: sh=lz, mant=s1_mant<<sh, exp=s1_exp-lz, uflow=0.
//   - z=0 and lz>exp: sh=s1_exp, mant=s1_mant<<s1_exp, exp=0, uflow=1 (gradual underflow).
//   - Compute sh as MANT_W-bit safe: compare in max(EXP_W, clog2(MANT_W)) + 1 bits; the subtraction never wraps.
//   - sign is passed through untouched in all cases.
//   - s2_valid clears on (valid_o & ready_i) when adv1 does not fire.
// - Latency and ordering:
//   - Latency is exactly 2 cycles from accept to valid_o when not stalled.
//   - Strict FIFO order; no drops, no duplicates.
// - Simultaneous events:
//   - Output accept and S1 advance in the same cycle: S2 reloads with no bubble.
//   - Input accept and S1 advance in the same cycle: S1 reloads.
// - Full: both stages valid and ready_i=0 gives ready_o=0; the 2 items are held.
// - Reset mid-operation: in-flight items are discarded; no partial output appears after release.
// STRUCTURE
// - Shared package fp_norm_pkg:
//   - typedef fp_unnorm_t {sign, exp, mant}
//   - typedef fp_norm_t {sign, exp, mant, zero, uflow}
//   - localparam LZ_W = $clog2(MANT_W)
// - One sub-module: detect_pos_first_one (existing), instanced on s1_mant.
// - The rest is flat: two stage registers, shifter and comparator.
// TESTING (MANT_W=16, EXP_W=8; ready_i=1 unless stated)
// - mant=0x0001 exp=20 s=1 -> 2 cycles later mant_o=0x8000 exp_o=5 sign_o=1 zero_o=0 uflow_o=0.
// - mant=0x8000 exp=3 -> mant_o=0x8000 exp_o=3 (no shift).
// - mant=0x0000 exp=77 -> zero_o=1 mant_o=0 exp_o=0 uflow_o=0.
// - mant=0x0010 exp=4 (lz=11>4) -> mant_o=0x0100 exp_o=0 uflow_o=1.
// - Back-to-back 6 items with ready_i=0 for cycles 3-7:
//   - ready_o drops after 2 are buffered; data stays stable.
//   - All 6 emerge in order and none are lost.
// - Random valid_i/ready_i for 10k items vs reference model -> exact match, valid_o held until accepted.
// - rst_n_i low for 1 cycle with both stages full -> valid_o=0 immediately (async).
//   - After release ready_o=1.
//   - The next item appears 2 cycles after accept.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared types and widths for the floating-point normalisation pipeline.
// No logic: widths, leading-zero count width and the stage payload structs.
// Backpressure: n/a (declarations only).
package fp_norm_pkg;

  localparam int FP_MANT_W = 16;
  localparam int FP_EXP_W  = 8;
  localparam int LZ_W      = $clog2(FP_MANT_W);

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp_unnorm_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
    logic                 zero;
    logic                 uflow;
  } fp_norm_t;

endpackage

// File: rtl/detect_pos_first_one.sv
// Leading-one detector: index of the most significant set bit of data_i.
// Latency: combinational. Backpressure: none; pos_o is 0 when data_i is 0.
// Callers that care about the all-zero case must detect it themselves.
module detect_pos_first_one #(
  parameter  int D_WIDTH = 16,
  localparam int P_W     = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1
) (
  input  logic [D_WIDTH-1:0] data_i,
  output logic [P_W-1:0]     pos_o
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < D_WIDTH; i++) begin
      if (data_i[i]) begin
        pos_o = P_W'(i);
      end
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Normalises {sign, exp, mant} so the mantissa MSB is set, limited by the exponent.
// Latency: 2 cycles (S1 register+detect, S2 shift+adjust); 1 item/cycle.
// Backpressure: elastic valid/ready, ready_i->ready_o combinational, holds 2 items when full.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [MANT_W-1:0] mant_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [MANT_W-1:0] mant_o,
  output logic              zero_o,
  output logic              uflow_o
);

  // Wide enough that neither the lz count nor the exponent can wrap in the compare.
  localparam int CMP_W = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;

  fp_unnorm_t        s1_q;
  logic              s1_valid;
  fp_norm_t          s2_q;
  fp_norm_t          s2_d;
  logic              s2_valid;

  logic              adv1;
  logic              accept;
  logic              z;
  logic [LZ_W-1:0]   msb_pos;
  logic [LZ_W-1:0]   lz;
  logic [LZ_W-1:0]   sh;
  logic [CMP_W-1:0]  lz_cmp;
  logic [CMP_W-1:0]  exp_cmp;

  assign adv1    = s1_valid & (~s2_valid | ready_i);
  assign ready_o = ~s1_valid | adv1;
  assign accept  = valid_i & ready_o;

  detect_pos_first_one #(
    .D_WIDTH (MANT_W)
  ) u_lead_one (
    .data_i (s1_q.mant),
    .pos_o  (msb_pos)
  );

  assign z       = (s1_q.mant == '0);
  assign lz      = LZ_W'(MANT_W - 1) - msb_pos;
  assign lz_cmp  = CMP_W'(lz);
  assign exp_cmp = CMP_W'(s1_q.exp);

  // Shift by lz when the exponent can absorb it, otherwise stop at exp=0 (denormal).
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    sh        = '0;
    if (z) begin
      s2_d.zero = 1'b1;
    end else if (lz_cmp <= exp_cmp) begin
      sh       = lz;
      s2_d.exp = s1_q.exp - EXP_W'(lz);
    end else begin
      sh         = LZ_W'(s1_q.exp);
      s2_d.uflow = 1'b1;
    end
    if (!z) begin
      s2_d.mant = s1_q.mant << sh;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_valid <= accept | (s1_valid & ~adv1);
      if (accept) begin
        s1_q.sign <= sign_i;
        s1_q.exp  <= exp_i;
        s1_q.mant <= mant_i;
      end
    end
  end

  // S2 only loads on adv1, which implies the held output was consumed or absent.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      s2_valid <= adv1 | (s2_valid & ~ready_i);
      if (adv1) begin
        s2_q <= s2_d;
      end
    end
  end

  assign valid_o = s2_valid;
  assign sign_o  = s2_q.sign;
  assign exp_o   = s2_q.exp;
  assign mant_o  = s2_q.mant;
  assign zero_o  = s2_q.zero;
  assign uflow_o = s2_q.uflow;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed and randomised bench for fp_normalize_pipe (MANT_W=16, EXP_W=8).
// Inputs driven 1ns after posedge, outputs sampled on negedge.
// Expected results come from hand tables and an iterative shift-until-normal model.
module tb_fp_normalize_pipe;

  logic        clk_i;
  logic        rst_n_i;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [15:0] mant_i;
  logic        valid_o;
  logic        ready_i;
  logic        sign_o;
  logic [7:0]  exp_o;
  logic [15:0] mant_o;
  logic        zero_o;
  logic        uflow_o;

  int vectors;
  int miscompares;

  wire [26:0] outs = {sign_o, exp_o, mant_o, zero_o, uflow_o};

  fp_normalize_pipe #(.MANT_W(16), .EXP_W(8)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sign_i  (sign_i),
    .exp_i   (exp_i),
    .mant_i  (mant_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sign_o  (sign_o),
    .exp_o   (exp_o),
    .mant_o  (mant_o),
    .zero_o  (zero_o),
    .uflow_o (uflow_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Hand-computed vectors: {sign, exp, mant, zero, uflow}
  logic        vs [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0]  ve [7] = '{8'd20, 8'd3, 8'd77, 8'd4, 8'd11, 8'd0, 8'd255};
  logic [15:0] vm [7] = '{16'h0001, 16'h8000, 16'h0000, 16'h0010, 16'h0010, 16'h0001, 16'h3FFF};
  logic [26:0] vx [7] = '{{1'b1, 8'd5,   16'h8000, 1'b0, 1'b0},
                          {1'b0, 8'd3,   16'h8000, 1'b0, 1'b0},
                          {1'b1, 8'd0,   16'h0000, 1'b1, 1'b0},
                          {1'b0, 8'd0,   16'h0100, 1'b0, 1'b1},
                          {1'b0, 8'd0,   16'h8000, 1'b0, 1'b0},
                          {1'b1, 8'd0,   16'h0001, 1'b0, 1'b1},
                          {1'b0, 8'd253, 16'hFFFC, 1'b0, 1'b0}};

  function automatic logic [26:0] model(input logic s, input logic [7:0] e, input logic [15:0] m);
    logic [7:0]  ee = e;
    logic [15:0] mm = m;
    logic        uf = 1'b0;
    if (m == 16'h0) return {s, 8'h00, 16'h0000, 1'b1, 1'b0};
    while (!mm[15]) begin
      if (ee == 8'h00) begin
        uf = 1'b1;
        break;
      end
      mm = mm << 1;
      ee = ee - 8'd1;
    end
    return {s, ee, mm, 1'b0, uf};
  endfunction

  task automatic test_reset();
    #2;
    vectors++;
    if (valid_o !== 1'b0 || outs !== 27'h0) begin
      miscompares++;
      $display("FAIL reset_outputs valid_o=%b outs=%h want 0/0", valid_o, outs);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    vectors++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release ready_o=%b valid_o=%b want 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_vectors();
    for (int k = 0; k < 7; k++) begin
      @(posedge clk_i); #1;
      ready_i = 1'b1; valid_i = 1'b1;
      sign_i = vs[k]; exp_i = ve[k]; mant_i = vm[k];
      @(negedge clk_i);
      vectors++;
      if (ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL vec%0d_ready ready_o=%b want 1", k, ready_o);
      end
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      @(negedge clk_i);
      vectors++;
      if (valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL vec%0d_early valid_o=%b want 0", k, valid_o);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      vectors++;
      if (valid_o !== 1'b1 || outs !== vx[k]) begin
        miscompares++;
        $display("FAIL vec%0d_result valid_o=%b outs=%h want 1/%h", k, valid_o, outs, vx[k]);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      vectors++;
      if (valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL vec%0d_drain valid_o=%b want 0", k, valid_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] q[$];
    logic [26:0] held = '0;
    logic [26:0] want;
    bit          was_stalled = 1'b0;
    int          sent = 0;
    int          got_n = 0;
    int          stall = 0;
    for (int cyc = 1; cyc <= 40 && got_n < 6; cyc++) begin
      @(posedge clk_i); #1;
      ready_i = !(cyc >= 3 && cyc <= 7);
      valid_i = (sent < 6);
      if (sent < 6) begin
        sign_i = vs[sent]; exp_i = ve[sent]; mant_i = vm[sent];
      end
      @(negedge clk_i);
      if (!ready_i && valid_i && !ready_o) stall++;
      if (was_stalled) begin
        vectors++;
        if (valid_o !== 1'b1 || outs !== held) begin
          miscompares++;
          $display("FAIL b2b_hold cyc%0d valid_o=%b outs=%h want 1/%h", cyc, valid_o, outs, held);
        end
      end
      if (valid_i && ready_o) begin
        q.push_back(vx[sent]);
        sent++;
      end
      if (valid_o && ready_i) begin
        want = (q.size() > 0) ? q.pop_front() : 27'h7FFFFFF;
        vectors++;
        if (outs !== want) begin
          miscompares++;
          $display("FAIL b2b_order item%0d outs=%h want %h", got_n, outs, want);
        end
        got_n++;
      end
      was_stalled = valid_o && !ready_i;
      held = outs;
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0; ready_i = 1'b1;
    vectors++;
    if (got_n != 6 || stall != 5) begin
      miscompares++;
      $display("FAIL b2b_count items=%0d stall_cycles=%0d want 6/5", got_n, stall);
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [26:0] q[$];
    logic [26:0] held = '0;
    logic [26:0] want;
    bit          was_stalled = 1'b0;
    bit          pend = 1'b0;
    int          sent = 0;
    int          got_n = 0;
    for (int cyc = 0; cyc < 60000 && got_n < N; cyc++) begin
      @(posedge clk_i); #1;
      ready_i = ($urandom_range(0, 3) != 0);
      if (!pend && sent < N && $urandom_range(0, 3) != 0) begin
        pend   = 1'b1;
        sign_i = 1'($urandom_range(0, 1));
        exp_i  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        mant_i = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      end
      valid_i = pend;
      @(negedge clk_i);
      if (was_stalled) begin
        vectors++;
        if (valid_o !== 1'b1 || outs !== held) begin
          miscompares++;
          $display("FAIL rnd_hold cyc%0d valid_o=%b outs=%h want 1/%h", cyc, valid_o, outs, held);
        end
      end
      if (valid_i && ready_o) begin
        q.push_back(model(sign_i, exp_i, mant_i));
        sent++;
        pend = 1'b0;
      end
      if (valid_o && ready_i) begin
        want = (q.size() > 0) ? q.pop_front() : 27'h7FFFFFF;
        vectors++;
        if (outs !== want) begin
          miscompares++;
          $display("FAIL rnd_data item%0d outs=%h want %h", got_n, outs, want);
        end
        got_n++;
      end
      was_stalled = valid_o && !ready_i;
      held = outs;
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0; ready_i = 1'b1;
    vectors++;
    if (got_n != N || q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_count items=%0d left=%0d want %0d/0", got_n, q.size(), N);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk_i); #1;
    ready_i = 1'b0; valid_i = 1'b1;
    sign_i = vs[0]; exp_i = ve[0]; mant_i = vm[0];
    @(posedge clk_i); #1;
    sign_i = vs[1]; exp_i = ve[1]; mant_i = vm[1];
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_full valid_o=%b ready_o=%b want 1/0", valid_o, ready_o);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    vectors++;
    if (valid_o !== 1'b0 || outs !== 27'h0) begin
      miscompares++;
      $display("FAIL mid_async valid_o=%b outs=%h want 0/0", valid_o, outs);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    ready_i = 1'b1;
    #1;
    vectors++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_release ready_o=%b valid_o=%b want 1/0", ready_o, valid_o);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b1;
    sign_i = vs[3]; exp_i = ve[3]; mant_i = vm[3];
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_stale valid_o=%b want 0", valid_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    vectors++;
    if (valid_o !== 1'b1 || outs !== vx[3]) begin
      miscompares++;
      $display("FAIL mid_next valid_o=%b outs=%h want 1/%h", valid_o, outs, vx[3]);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    sign_i  = 1'b0;
    exp_i   = 8'h00;
    mant_i  = 16'h0000;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
